// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, counter width and the cell geometry
// that the downstream pixel generator is built around.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   localparam int VGA_CELL_W  = 21;
   localparam int VGA_CELLS_X = 30;

   typedef enum logic {
      ST_RESYNC,
      ST_RUN
   } tg_state_e;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int bitsFor(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Divides the system clock down to a one-cycle pixel tick every CLK_DIV clocks.
module pixel_tick_divider
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);

   localparam int DIV_W = bitsFor(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic             w_tick;

   // With CLK_DIV == 1 the counter is pinned at zero, which already equals DIV_LAST.
   assign w_tick = (r_div == DIV_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   assign o_tick = w_tick;

endmodule

// File: rtl/vga_timing_generator.sv
// Raster counters, cell tracking and registered strobes/levels feeding the pixel generator.
module vga_timing_generator
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int CELL_W   = VGA_CELL_W,
   parameter int CELLS_X  = VGA_CELLS_X
) (
   input  logic             i_clk,
   input  logic             i_reset,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic             o_line_start,
   output logic             o_cell_adv,
   output logic             o_row_adv,
   output logic             o_frame_start,
   output logic             o_vblank_start,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int PX_W         = bitsFor(CELL_W);
   localparam int IDX_W        = bitsFor(CELLS_X);

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_BEGIN   = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] HS_STOP    = CNT_W'(H_SYNC_END);
   localparam logic [CNT_W-1:0] VS_BEGIN   = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] VS_STOP    = CNT_W'(V_SYNC_END);
   localparam logic [PX_W-1:0]  PX_LAST    = PX_W'(CELL_W - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CELLS_X - 1);

   logic             w_tick;
   tg_state_e        r_state;
   tg_state_e        w_state_next;

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic [CNT_W-1:0] w_h_next;
   logic [CNT_W-1:0] w_v_next;
   logic [PX_W-1:0]  r_cell_px;
   logic [PX_W-1:0]  w_cell_px_next;
   logic [IDX_W-1:0] r_cell_idx;
   logic [IDX_W-1:0] w_cell_idx_next;

   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_h_active;
   logic             w_v_active;
   logic             w_cell_last_px;
   logic             w_cell_adv;
   logic             w_line_start;
   logic             w_row_adv;
   logic             w_vblank_start;
   logic             w_frame_start;
   logic             w_hsync_n;
   logic             w_vsync_n;
   logic             w_de;

   logic             r_hsync;
   logic             r_vsync;
   logic             r_de;
   logic             r_line_start;
   logic             r_cell_adv;
   logic             r_row_adv;
   logic             r_frame_start;
   logic             r_vblank_start;
   logic [CNT_W-1:0] r_h_out;
   logic [CNT_W-1:0] r_v_out;

   pixel_tick_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_divider (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_tick  (w_tick)
   );

   // RESYNC marks that the next tick must also announce a new frame to the generator.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_RESYNC;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RESYNC: if (w_tick) w_state_next = ST_RUN;
         ST_RUN:    w_state_next = ST_RUN;
         default:   w_state_next = ST_RESYNC;
      endcase
   end

   always_comb begin
      w_h_wrap       = (r_h_cnt == H_LAST);
      w_v_wrap       = (r_v_cnt == V_LAST);
      w_h_active     = (r_h_cnt < H_ACT_END);
      w_v_active     = (r_v_cnt < V_ACT_END);
      w_cell_last_px = (r_cell_px == PX_LAST);
      w_cell_adv     = w_h_active && w_cell_last_px && (r_cell_idx < IDX_LAST);
      w_line_start   = w_h_wrap;
      w_row_adv      = (r_h_cnt == H_ACT_LAST) && w_v_active;
      w_vblank_start = w_h_wrap && (r_v_cnt == V_ACT_LAST);
      w_frame_start  = (w_h_wrap && w_v_wrap) || (r_state == ST_RESYNC);
      w_hsync_n      = !((r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_STOP));
      w_vsync_n      = !((r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_STOP));
      w_de           = w_h_active && w_v_active;
   end

   // The last cell of a row absorbs the leftover pixels, so its index saturates.
   always_comb begin
      w_h_next        = r_h_cnt + CNT_W'(1);
      w_v_next        = r_v_cnt;
      w_cell_px_next  = r_cell_px;
      w_cell_idx_next = r_cell_idx;
      if (w_h_wrap) begin
         w_h_next        = '0;
         w_cell_px_next  = '0;
         w_cell_idx_next = '0;
         w_v_next        = w_v_wrap ? '0 : (r_v_cnt + CNT_W'(1));
      end else if (w_h_active) begin
         if (w_cell_last_px) begin
            w_cell_px_next = '0;
            if (r_cell_idx < IDX_LAST) begin
               w_cell_idx_next = r_cell_idx + IDX_W'(1);
            end
         end else begin
            w_cell_px_next = r_cell_px + PX_W'(1);
         end
      end
   end

   // Outputs capture the pre-advance state on each tick; strobes drop on every non-tick cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_h_cnt        <= '0;
         r_v_cnt        <= '0;
         r_cell_px      <= '0;
         r_cell_idx     <= '0;
         r_hsync        <= 1'b1;
         r_vsync        <= 1'b1;
         r_de           <= 1'b0;
         r_line_start   <= 1'b0;
         r_cell_adv     <= 1'b0;
         r_row_adv      <= 1'b0;
         r_frame_start  <= 1'b0;
         r_vblank_start <= 1'b0;
         r_h_out        <= '0;
         r_v_out        <= '0;
      end else if (w_tick) begin
         r_h_cnt        <= w_h_next;
         r_v_cnt        <= w_v_next;
         r_cell_px      <= w_cell_px_next;
         r_cell_idx     <= w_cell_idx_next;
         r_hsync        <= w_hsync_n;
         r_vsync        <= w_vsync_n;
         r_de           <= w_de;
         r_line_start   <= w_line_start;
         r_cell_adv     <= w_cell_adv;
         r_row_adv      <= w_row_adv;
         r_frame_start  <= w_frame_start;
         r_vblank_start <= w_vblank_start;
         r_h_out        <= r_h_cnt;
         r_v_out        <= r_v_cnt;
      end else begin
         r_line_start   <= 1'b0;
         r_cell_adv     <= 1'b0;
         r_row_adv      <= 1'b0;
         r_frame_start  <= 1'b0;
         r_vblank_start <= 1'b0;
      end
   end

   assign o_hsync        = r_hsync;
   assign o_vsync        = r_vsync;
   assign o_de           = r_de;
   assign o_line_start   = r_line_start;
   assign o_cell_adv     = r_cell_adv;
   assign o_row_adv      = r_row_adv;
   assign o_frame_start  = r_frame_start;
   assign o_vblank_start = r_vblank_start;
   assign o_h_cnt        = r_h_out;
   assign o_v_cnt        = r_v_out;

endmodule
